// File: rtl/alu_pkg.sv
// alu_pkg: op codes, controller states and op-class helpers shared by the serial ALU.
package alu_pkg;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   function automatic logic is_arith(input logic [3:0] op);
      return op == OP_ADD || op == OP_SUB || op == OP_SLT;
   endfunction

   function automatic logic is_legal(input logic [3:0] op);
      return is_arith(op) || op == OP_AND || op == OP_OR || op == OP_XOR || op == OP_NOR;
   endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: one-bit ALU; SUB inverts b, unsupported ops yield 0 with no carry.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic [3:0] op,
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   output logic       r,
   output logic       cout
);
   logic bx, add_sub;
   always_comb begin
      bx = (op == OP_SUB) ? ~b : b;
      add_sub = op == OP_ADD || op == OP_SUB;
      r = (op == OP_AND) ? (a & b) :
          (op == OP_OR)  ? (a | b) :
          (op == OP_XOR) ? (a ^ b) :
          (op == OP_NOR) ? ~(a | b) :
          add_sub        ? (a ^ bx ^ cin) : 1'b0;
      cout = add_sub & ((a & bx) | (cin & (a ^ bx)));
   end
endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: streams latched operands LSB-first through one alu_bit_slice
// and presents the word result and flags behind a valid/ready handshake.
module bit_serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             illegal_op
);
   state_t state, state_d;
   logic [WIDTH-1:0] sa, sb, sr, res_w;
   logic [3:0] op_r, slice_op;
   logic [CNT_W-1:0] cnt;
   logic carry, r, cout, last, arith, ovf;

   // SLT runs as a subtraction; its result is derived from the sign at the end
   assign slice_op = (op_r == OP_SLT) ? OP_SUB : op_r;

   alu_bit_slice u_slice (
      .op  (slice_op),
      .a   (sa[0]),
      .b   (sb[0]),
      .cin (carry),
      .r   (r),
      .cout(cout)
   );

   always_comb begin
      arith = is_arith(op_r);
      last = cnt == CNT_W'(WIDTH - 1);
      // on the last bit, carry still holds the MSB carry-in
      ovf = arith & (carry ^ cout);
      res_w = (op_r == OP_SLT) ? {{(WIDTH-1){1'b0}}, r ^ ovf} : {r, sr[WIDTH-1:1]};
      in_ready = state == ST_IDLE;
      out_valid = state == ST_DONE;
      state_d = (state == ST_IDLE && in_valid)  ? ST_RUN  :
                (state == ST_RUN  && last)      ? ST_DONE :
                (state == ST_DONE && out_ready) ? ST_IDLE : state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sa         <= '0;
         sb         <= '0;
         sr         <= '0;
         op_r       <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         result     <= '0;
         carry_out  <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         state <= state_d;
         if (state == ST_IDLE && in_valid) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            op_r  <= op;
            cnt   <= '0;
            carry <= op == OP_SUB || op == OP_SLT;
         end else if (state == ST_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sr    <= {r, sr[WIDTH-1:1]};
            carry <= arith & cout;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
               result     <= res_w;
               carry_out  <= arith & cout;
               overflow   <= ovf;
               zero       <= res_w == '0;
               illegal_op <= !is_legal(op_r);
            end
         end
      end
   end
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb_bit_serial_alu_ctrl: directed and random operations checked against an arithmetic model.
module tb_bit_serial_alu_ctrl;
   localparam int W = 8;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [3:0] op = 0;
   logic [W-1:0] a = 0, b = 0;
   logic in_ready, out_valid, carry_out, overflow, zero, illegal_op;
   logic [W-1:0] result;
   int pass = 0, total = 0;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carry_out(carry_out), .overflow(overflow), .zero(zero), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // {result, carry_out, overflow, zero, illegal_op}
   function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      logic [W-1:0] res;
      logic co, ov, il;
      res = 0; co = 0; ov = 0; il = 0;
      case (o)
         4'b0000: res = x & y;
         4'b0001: res = x | y;
         4'b0100: res = x ^ y;
         4'b1100: res = ~(x | y);
         4'b0010: begin
            s = {1'b0, x} + {1'b0, y};
            res = s[W-1:0]; co = s[W];
            ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
         end
         4'b0110, 4'b0111: begin
            s = {1'b0, x} + {1'b0, ~y} + 1;
            res = s[W-1:0]; co = s[W];
            ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
            if (o == 4'b0111) res = ($signed(x) < $signed(y)) ? 1 : 0;
         end
         default: il = 1;
      endcase
      return {res, co, ov, res == 0, il};
   endfunction

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W+3:0] got, output int lat);
      @(negedge clk);
      in_valid = 1; op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = k; break; end
      end
      got = {result, carry_out, overflow, zero, illegal_op};
      if (lat < 0) begin
         $display("FAIL timeout op=%b: out_valid never rose", o);
         total++;
      end
      @(negedge clk); out_ready = 1;
      @(posedge clk); #1; out_ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs got %b want 10", {in_ready, out_valid});
      else pass++;
      total++;
      if ({result, carry_out, overflow, zero, illegal_op} !== '0)
         $display("FAIL reset_out got %h want 0", {result, carry_out, overflow, zero, illegal_op});
      else pass++;
      total++;
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_add();
      logic [W+3:0] got; int lat;
      run_op(4'b0010, 8'h7F, 8'h01, got, lat);
      if (got !== {8'h80, 4'b0100}) $display("FAIL add_7f_01 got %h want %h", got, {8'h80, 4'b0100});
      else pass++;
      total++;
      if (lat != W) $display("FAIL add_latency got %0d want %0d", lat, W);
      else pass++;
      total++;
   endtask

   task automatic test_sub_slt();
      logic [W+3:0] got; int lat;
      logic [3:0] ops [6] = '{4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
      logic [W-1:0] xs [6] = '{8'h05, 8'h00, 8'h80, 8'h01, 8'h7F, 8'h03};
      logic [W-1:0] ys [6] = '{8'h05, 8'h01, 8'h01, 8'h80, 8'h80, 8'h03};
      logic [W+3:0] exp [6] = '{{8'h00, 4'b1010}, {8'hFF, 4'b0000}, {8'h01, 4'b1100},
                                {8'h00, 4'b0110}, {8'h00, 4'b0110}, {8'h00, 4'b1010}};
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], xs[i], ys[i], got, lat);
         if (got !== exp[i]) $display("FAIL subslt_%0d got %h want %h", i, got, exp[i]);
         else pass++;
         total++;
      end
   endtask

   task automatic test_logic();
      logic [W+3:0] got; int lat;
      logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0100, 4'b1100, 4'b0011};
      logic [W-1:0] exp [5] = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'h00};
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], 8'hF0, 8'h3C, got, lat);
         if (got !== {exp[i], 2'b00, exp[i] == 0, i == 4})
            $display("FAIL logic_op%b got %h want %h", ops[i], got, {exp[i], 2'b00, exp[i] == 0, i == 4});
         else pass++;
         total++;
      end
   endtask

   task automatic test_random();
      logic [W+3:0] got, exp; int lat;
      logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1100, 4'b0000};
      logic [3:0] o;
      logic [W-1:0] x, y;
      for (int i = 0; i < 40; i++) begin
         o = ops[$urandom_range(0, 7)];
         if (i % 8 == 7) o = 4'($urandom_range(0, 15));
         x = 8'($urandom); y = 8'($urandom);
         exp = model(o, x, y);
         run_op(o, x, y, got, lat);
         if (got !== exp || lat != W)
            $display("FAIL rand op=%b a=%h b=%h got %h lat %0d want %h lat %0d", o, x, y, got, lat, exp, W);
         else pass++;
         total++;
      end
   endtask

   task automatic test_backpressure();
      logic [W+3:0] got, snap; int lat;
      @(negedge clk);
      in_valid = 1; op = 4'b0110; a = 8'h20; b = 8'h30;
      @(posedge clk); #1;
      op = 4'b0010; a = 8'h01; b = 8'h01;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = k; break; end
      end
      snap = {result, carry_out, overflow, zero, illegal_op};
      if (lat != W || snap !== model(4'b0110, 8'h20, 8'h30))
         $display("FAIL bp_result got %h lat %0d want %h lat %0d", snap, lat, model(4'b0110, 8'h20, 8'h30), W);
      else pass++;
      total++;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if ({out_valid, in_ready, result, carry_out, overflow, zero, illegal_op} !== {2'b10, snap})
            $display("FAIL bp_hold_%0d got %h want %h", k,
                     {out_valid, in_ready, result, carry_out, overflow, zero, illegal_op}, {2'b10, snap});
         else pass++;
         total++;
      end
      @(negedge clk); in_valid = 0; out_ready = 1;
      @(posedge clk); #1; out_ready = 0;
      if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {out_valid, in_ready});
      else pass++;
      total++;
      run_op(4'b0001, 8'h0A, 8'h50, got, lat);
      if (got !== model(4'b0001, 8'h0A, 8'h50) || lat != W)
         $display("FAIL bp_next got %h want %h", got, model(4'b0001, 8'h0A, 8'h50));
      else pass++;
      total++;
   endtask

   task automatic test_reset_mid_run();
      logic [W+3:0] got; int lat, seen;
      @(negedge clk);
      in_valid = 1; op = 4'b0010; a = 8'hFF; b = 8'h01;
      @(posedge clk); #1; in_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 0;
      @(posedge clk); #1; rst_n = 1;
      if ({in_ready, out_valid, result, carry_out, overflow, zero, illegal_op} !== {2'b10, 12'h0})
         $display("FAIL midrst got %h want %h",
                  {in_ready, out_valid, result, carry_out, overflow, zero, illegal_op}, {2'b10, 12'h0});
      else pass++;
      total++;
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (out_valid) seen++; end
      if (seen != 0) $display("FAIL midrst_emit got %0d valid cycles want 0", seen);
      else pass++;
      total++;
      run_op(4'b0010, 8'h10, 8'h20, got, lat);
      if (got !== {8'h30, 4'b0000} || lat != W) $display("FAIL post_rst_add got %h want %h", got, {8'h30, 4'b0000});
      else pass++;
      total++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_logic();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
